// File: rtl/bsg_gateway_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// bsg_gateway_rst_seq_pkg
//   Shared types and constants for the gateway reset sequencer.
//   - rst_seq_state_e        : sequencer FSM states
//   - lock_loss_cnt_width_gp : width of the lock-loss event counter output
// -----------------------------------------------------------------------------
package bsg_gateway_rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        TAG_REL   = 3'd2,
        IO_REL    = 3'd3,
        RUN       = 3'd4
    } rst_seq_state_e;

    localparam int lock_loss_cnt_width_gp = 8;

endpackage

// File: rtl/bsg_gateway_rst_seq_sync.sv
// -----------------------------------------------------------------------------
// bsg_gateway_rst_seq_sync
//   Two-flop synchronizer bringing an asynchronous level into the clk_i domain.
//   Output has two cycles of latency; both flops clear to 0 on reset_i.
// Ports
//   clk_i    in  destination clock
//   reset_i  in  asynchronous active-high reset
//   d_i      in  asynchronous input level
//   q_o      out synchronized level
// -----------------------------------------------------------------------------
module bsg_gateway_rst_seq_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bsg_gateway_reset_sequencer.sv
// -----------------------------------------------------------------------------
// bsg_gateway_reset_sequencer
//   Watches the clock generator's combined PLL/DCM lock and releases the
//   gateway resets in order tag -> io -> core once lock has been stable.
//   Any lock loss (or a software request while running) re-asserts all
//   three resets on a single edge.
//
// Optional feature (macro BSG_GATEWAY_RST_SEQ_LOSS_CNT_EN):
//   defined     -> lock_loss_cnt_o counts lock losses taken from RUN,
//                  saturating at all-ones, cleared only by reset_i.
//   not defined -> no counter flops, lock_loss_cnt_o tied to zero.
//
// Ports
//   clk_i            in   microblaze clock
//   reset_i          in   asynchronous active-high reset
//   locked_i         in   PLL&DCM lock, asynchronous to clk_i
//   sw_reset_i       in   one-cycle software reset request (honoured in RUN)
//   tag_reset_o      out  tag domain reset, active-high
//   io_reset_o       out  io master/serdes reset, active-high
//   core_reset_o     out  core reset, active-high
//   done_o           out  sequence complete (state RUN)
//   lock_loss_cnt_o  out  saturating lock-loss count
//   state_o          out  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module bsg_gateway_reset_sequencer
    import bsg_gateway_rst_seq_pkg::*;
#(
    parameter int lock_stable_cycles_p = 1024,
    parameter int io_hold_cycles_p     = 256,
    parameter int core_hold_cycles_p   = 256,
    parameter int cnt_width_p          = 16
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              locked_i,
    input  logic                              sw_reset_i,
    output logic                              tag_reset_o,
    output logic                              io_reset_o,
    output logic                              core_reset_o,
    output logic                              done_o,
    output logic [lock_loss_cnt_width_gp-1:0] lock_loss_cnt_o,
    output rst_seq_state_e                    state_o
);

    // Terminal counts: each hold state lasts exactly *_cycles_p edges.
    localparam logic [cnt_width_p-1:0] stable_last_lp = cnt_width_p'(lock_stable_cycles_p - 1);
    localparam logic [cnt_width_p-1:0] io_last_lp     = cnt_width_p'(io_hold_cycles_p - 1);
    localparam logic [cnt_width_p-1:0] core_last_lp   = cnt_width_p'(core_hold_cycles_p - 1);

    logic                   locked_sync;
    rst_seq_state_e         state_q, state_d;
    logic [cnt_width_p-1:0] cnt_q, cnt_d;
    logic                   tag_q, tag_d;
    logic                   io_q, io_d;
    logic                   core_q, core_d;
    logic                   done_q, done_d;

    bsg_gateway_rst_seq_sync u_lock_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (locked_i),
        .q_o     (locked_sync)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            tag_q   <= 1'b1;
            io_q    <= 1'b1;
            core_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            io_q    <= io_d;
            core_q  <= core_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + cnt_width_p'(1);
        tag_d   = tag_q;
        io_d    = io_q;
        core_d  = core_q;
        done_d  = done_q;

        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_sync) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (cnt_q == stable_last_lp) begin
                    state_d = TAG_REL;
                    cnt_d   = '0;
                    tag_d   = 1'b0;
                end
            end
            TAG_REL: begin
                if (cnt_q == io_last_lp) begin
                    state_d = IO_REL;
                    cnt_d   = '0;
                    io_d    = 1'b0;
                end
            end
            IO_REL: begin
                if (cnt_q == core_last_lp) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    core_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            RUN: begin
                // Counter parks at zero while running so it can never wrap.
                cnt_d = '0;
                if (sw_reset_i) begin
                    state_d = STABLE;
                    tag_d   = 1'b1;
                    io_d    = 1'b1;
                    core_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                tag_d   = 1'b1;
                io_d    = 1'b1;
                core_d  = 1'b1;
                done_d  = 1'b0;
            end
        endcase

        // Lock loss overrides everything, including a same-cycle sw_reset_i.
        if (state_q != WAIT_LOCK && !locked_sync) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            tag_d   = 1'b1;
            io_d    = 1'b1;
            core_d  = 1'b1;
            done_d  = 1'b0;
        end
    end

    assign tag_reset_o  = tag_q;
    assign io_reset_o   = io_q;
    assign core_reset_o = core_q;
    assign done_o       = done_q;
    assign state_o      = state_q;

`ifdef BSG_GATEWAY_RST_SEQ_LOSS_CNT_EN
    logic [lock_loss_cnt_width_gp-1:0] loss_cnt_q, loss_cnt_d;
    logic                              loss_from_run;

    // Only losses that tear down a fully released system are counted.
    assign loss_from_run = (state_q == RUN) && !locked_sync;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_from_run && (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + lock_loss_cnt_width_gp'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt_o = loss_cnt_q;
`else
    assign lock_loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_gateway_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bsg_gateway_reset_sequencer
//   Directed and randomized checks of the gateway reset sequencer with
//   lock_stable=8, io_hold=4, core_hold=4. The reference model tracks the
//   elapsed time of the current lock "attempt" and derives each reset from
//   simple thresholds on that time.
// -----------------------------------------------------------------------------
module tb_bsg_gateway_reset_sequencer;
    import bsg_gateway_rst_seq_pkg::*;

    localparam int S_P = 8;
    localparam int I_P = 4;
    localparam int C_P = 4;
    localparam int T_TAG  = S_P;
    localparam int T_IO   = S_P + I_P;
    localparam int T_DONE = S_P + I_P + C_P;

`ifdef BSG_GATEWAY_RST_SEQ_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_i;
    logic locked_i;
    logic sw_reset_i;
    logic tag_reset_o, io_reset_o, core_reset_o, done_o;
    logic [7:0] lock_loss_cnt_o;
    rst_seq_state_e state_o;

    always #5 clk = ~clk;

    bsg_gateway_reset_sequencer #(
        .lock_stable_cycles_p (S_P),
        .io_hold_cycles_p     (I_P),
        .core_hold_cycles_p   (C_P),
        .cnt_width_p          (16)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .locked_i        (locked_i),
        .sw_reset_i      (sw_reset_i),
        .tag_reset_o     (tag_reset_o),
        .io_reset_o      (io_reset_o),
        .core_reset_o    (core_reset_o),
        .done_o          (done_o),
        .lock_loss_cnt_o (lock_loss_cnt_o),
        .state_o         (state_o)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_active: an attempt is in progress (lock seen, not yet lost)
    // m_t     : edges since the attempt (re)started, capped at T_DONE
    bit m_active;
    int m_t;
    bit m_ls1, m_ls2;
    int m_loss;

    function automatic void model_reset();
        m_active = 0;
        m_t      = 0;
        m_ls1    = 0;
        m_ls2    = 0;
        m_loss   = 0;
    endfunction

    function automatic void model_edge(input bit lk, input bit sw);
        bit ls;
        ls = m_ls2;
        if (m_active && !ls) begin
            if (m_t >= T_DONE && m_loss < 255) m_loss++;
            m_active = 0;
            m_t      = 0;
        end else if (!m_active && ls) begin
            m_active = 1;
            m_t      = 0;
        end else if (m_active && m_t >= T_DONE && sw) begin
            m_t = 0;
        end else if (m_active && m_t < T_DONE) begin
            m_t++;
        end
        m_ls2 = m_ls1;
        m_ls1 = lk;
    endfunction

    task automatic check_model();
        chk("tag_reset",  {31'd0, tag_reset_o},  {31'd0, !(m_active && m_t >= T_TAG)});
        chk("io_reset",   {31'd0, io_reset_o},   {31'd0, !(m_active && m_t >= T_IO)});
        chk("core_reset", {31'd0, core_reset_o}, {31'd0, !(m_active && m_t >= T_DONE)});
        chk("done",       {31'd0, done_o},       {31'd0,  (m_active && m_t >= T_DONE)});
        chk("loss_cnt",   {24'd0, lock_loss_cnt_o}, CNT_EN ? m_loss : 0);
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit lk, input bit sw);
        locked_i   = lk;
        sw_reset_i = sw;
        @(posedge clk);
        model_edge(lk, sw);
        @(negedge clk);
        check_model();
    endtask

    task automatic measure_release(output int tag_e, output int io_e, output int core_e);
        tag_e = -1; io_e = -1; core_e = -1;
        for (int e = 0; e < 22; e++) begin
            step(1'b1, 1'b0);
            if (tag_e  < 0 && tag_reset_o  === 1'b0) tag_e  = e;
            if (io_e   < 0 && io_reset_o   === 1'b0) io_e   = e;
            if (core_e < 0 && core_reset_o === 1'b0) core_e = e;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int te, ie, ce, le;
        bit released;
        bit lk;

        reset_i    = 1'b1;
        locked_i   = 1'b0;
        sw_reset_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_tag",  {31'd0, tag_reset_o},  32'd1);
        chk("rst_io",   {31'd0, io_reset_o},   32'd1);
        chk("rst_core", {31'd0, core_reset_o}, 32'd1);
        chk("rst_done", {31'd0, done_o},       32'd0);
        chk("rst_cnt",  {24'd0, lock_loss_cnt_o}, 32'd0);
        chk("rst_state", {29'd0, state_o}, {29'd0, WAIT_LOCK});
        reset_i = 1'b0;

        // Power-up: lock present from edge 0.
        measure_release(te, ie, ce);
        chk("pwr_tag_edge",  te, 10);
        chk("pwr_io_edge",   ie, 14);
        chk("pwr_core_edge", ce, 18);
        chk("pwr_state", {29'd0, state_o}, {29'd0, RUN});

        // Lock loss in RUN: all resets back three edges after locked_i drops.
        le = -1;
        for (int e = 0; e < 6; e++) begin
            step(1'b0, 1'b0);
            if (le < 0 && tag_reset_o === 1'b1) le = e;
        end
        chk("loss_edge", le, 2);
        chk("loss_done", {31'd0, done_o}, 32'd0);
        chk("loss_cnt1", {24'd0, lock_loss_cnt_o}, CNT_EN ? 32'd1 : 32'd0);

        // Relock: identical timing.
        measure_release(te, ie, ce);
        chk("relock_tag_edge",  te, 10);
        chk("relock_io_edge",   ie, 14);
        chk("relock_core_edge", ce, 18);

        // Software reset while running.
        step(1'b1, 1'b1);
        chk("sw_all_reset", {29'd0, tag_reset_o, io_reset_o, core_reset_o}, 32'd7);
        te = -1; ie = -1; ce = -1;
        for (int e = 1; e < 20; e++) begin
            step(1'b1, 1'b0);
            if (te < 0 && tag_reset_o  === 1'b0) te = e;
            if (ie < 0 && io_reset_o   === 1'b0) ie = e;
            if (ce < 0 && core_reset_o === 1'b0) ce = e;
        end
        chk("sw_tag_edge",  te, 8);
        chk("sw_io_edge",   ie, 12);
        chk("sw_core_edge", ce, 16);

        // sw_reset_i in the cycle locked_sync is low: lock loss wins.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("swloss_state", {29'd0, state_o}, {29'd0, WAIT_LOCK});
        released = 0;
        for (int e = 0; e < 10; e++) begin
            step(1'b0, 1'b0);
            if (tag_reset_o !== 1'b1 || io_reset_o !== 1'b1 || core_reset_o !== 1'b1) released = 1;
        end
        chk("swloss_no_release", {31'd0, released}, 32'd0);

        // Short lock glitch never releases anything.
        released = 0;
        for (int e = 0; e < 25; e++) begin
            step(e < 5, 1'b0);
            if (tag_reset_o !== 1'b1 || io_reset_o !== 1'b1 || core_reset_o !== 1'b1) released = 1;
        end
        chk("glitch_no_release", {31'd0, released}, 32'd0);
        chk("glitch_state", {29'd0, state_o}, {29'd0, WAIT_LOCK});

        // Randomized lock toggling and software requests.
        lk = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 39) == 0) lk = !lk;
            step(lk, $urandom_range(0, 29) == 0);
        end

        // Many losses from RUN: counter saturates.
        for (int e = 0; e < 4; e++) step(1'b0, 1'b0);
        for (int k = 0; k < 300; k++) begin
            for (int e = 0; e < 20; e++) step(1'b1, 1'b0);
            for (int e = 0; e < 4; e++)  step(1'b0, 1'b0);
        end
        chk("loss_cnt_sat", {24'd0, lock_loss_cnt_o}, CNT_EN ? 32'hFF : 32'd0);

        // Asynchronous reset in the middle of IO_REL.
        for (int e = 0; e < 16; e++) step(1'b1, 1'b0);
        chk("mid_io_state", {29'd0, state_o}, {29'd0, IO_REL});
        reset_i = 1'b1;
        #1;
        model_reset();
        chk("async_tag",   {31'd0, tag_reset_o},  32'd1);
        chk("async_io",    {31'd0, io_reset_o},   32'd1);
        chk("async_core",  {31'd0, core_reset_o}, 32'd1);
        chk("async_done",  {31'd0, done_o},       32'd0);
        chk("async_cnt",   {24'd0, lock_loss_cnt_o}, 32'd0);
        chk("async_state", {29'd0, state_o}, {29'd0, WAIT_LOCK});
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        measure_release(te, ie, ce);
        chk("post_rst_tag_edge", te, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
